aes_inv_key_schedule: RTL

- Iterative inverse AES-128 key schedule for the decryption datapath.
- Accepts the last round key (round NR) and walks the schedule backwards, one round per accepted output.
- Emits round keys NR, NR-1, ... 0 in the order the inverse cipher consumes them, over a valid/ready stream.
- Complements the combinational forward expander: it needs only one 4-S-box word-substitution unit instead of ten unrolled stages.

---
 rtl/aes_inv_key_schedule_if.sv | 30 +++
 rtl/aes_inv_key_schedule.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/aes_inv_key_schedule_if.sv
// ============================================================================
// Module   : aes_inv_key_schedule_if
// Brief    : Start request and round-key stream bundle for the inverse AES-128
//            key schedule.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface aes_inv_key_schedule_if;
    logic         start;
    logic [127:0] key_in;
    logic         busy;
    logic         rk_valid;
    logic         rk_ready;
    logic [127:0] rk_out;
    logic [3:0]   rk_round;
    logic         done;

    modport master (
        output start, key_in, rk_ready,
        input  busy, rk_valid, rk_out, rk_round, done
    );

    modport slave (
        input  start, key_in, rk_ready,
        output busy, rk_valid, rk_out, rk_round, done
    );
endinterface

`default_nettype wire

// File: rtl/aes_inv_key_schedule.sv
// ============================================================================
// Module   : aes_inv_key_schedule
// Brief    : Iterative inverse AES-128 key schedule; walks from round NR back
//            to round 0, one key per accepted handshake.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

// AES S-box computed as GF(2^8) inverse (a^254) followed by the affine map.
module aes_inv_key_schedule_sbox (
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] sh;
        acc = 8'h00;
        sh  = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ sh;
            sh = {sh[6:0], 1'b0} ^ (sh[7] ? 8'h1b : 8'h00);
        end
        return acc;
    endfunction

    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] s;
        r = 8'h01;
        s = a;
        for (int i = 1; i < 8; i++) begin
            s = gf_mul(s, s);
            r = gf_mul(r, s);
        end
        return r;
    endfunction

    logic [7:0] w_inv;

    assign w_inv    = gf_inv(in_byte);
    assign out_byte = w_inv
                    ^ {w_inv[6:0], w_inv[7]}
                    ^ {w_inv[5:0], w_inv[7:6]}
                    ^ {w_inv[4:0], w_inv[7:5]}
                    ^ {w_inv[3:0], w_inv[7:4]}
                    ^ 8'h63;
endmodule

module aes_inv_key_schedule #(
    parameter int NR = 10
) (
    input  logic                   clk,
    input  logic                   rst,
    aes_inv_key_schedule_if.slave  bus
);
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_EMIT = 1'b1;

    localparam logic [3:0] C_NR_ROUND = NR[3:0];

    logic [0:0]   r_state;
    logic [127:0] r_cur;
    logic [3:0]   r_round;
    logic         r_done;

    logic [31:0]  w_w4, w_w5, w_w6, w_w7;
    logic [31:0]  w_n0, w_n1, w_n2, w_n3;
    logic [31:0]  w_rot;
    logic [31:0]  w_sub;
    logic [3:0]   w_prev_round;
    logic [7:0]   w_rcon;

    assign w_w4 = r_cur[127:96];
    assign w_w5 = r_cur[95:64];
    assign w_w6 = r_cur[63:32];
    assign w_w7 = r_cur[31:0];

    // Undo the forward recurrence from the last word downwards; w_n3 feeds w_n0.
    assign w_n3  = w_w7 ^ w_w6;
    assign w_n2  = w_w6 ^ w_w5;
    assign w_n1  = w_w5 ^ w_w4;
    assign w_rot = {w_n3[23:0], w_n3[31:24]};

    generate
        for (genvar g = 0; g < 4; g++) begin : g_sbox
            aes_inv_key_schedule_sbox u_sbox (
                .in_byte  (w_rot[8*g +: 8]),
                .out_byte (w_sub[8*g +: 8])
            );
        end
    endgenerate

    assign w_prev_round = r_round - 4'd1;

    always_comb begin
        w_rcon = 8'h00;
        case (w_prev_round)
            4'd0:    w_rcon = 8'h01;
            4'd1:    w_rcon = 8'h02;
            4'd2:    w_rcon = 8'h04;
            4'd3:    w_rcon = 8'h08;
            4'd4:    w_rcon = 8'h10;
            4'd5:    w_rcon = 8'h20;
            4'd6:    w_rcon = 8'h40;
            4'd7:    w_rcon = 8'h80;
            4'd8:    w_rcon = 8'h1b;
            4'd9:    w_rcon = 8'h36;
            default: w_rcon = 8'h00;
        endcase
    end

    assign w_n0 = w_w4 ^ w_sub ^ {w_rcon, 24'h000000};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cur   <= '0;
            r_round <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // A start coinciding with the done pulse is dropped.
                    if (bus.start && !r_done) begin
                        r_cur   <= bus.key_in;
                        r_round <= C_NR_ROUND;
                        r_state <= S_EMIT;
                    end
                end
                S_EMIT: begin
                    if (bus.rk_ready) begin
                        if (r_round != 4'd0) begin
                            r_cur   <= {w_n0, w_n1, w_n2, w_n3};
                            r_round <= w_prev_round;
                        end else begin
                            r_state <= S_IDLE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy     = (r_state == S_EMIT);
    assign bus.rk_valid = (r_state == S_EMIT);
    assign bus.rk_out   = r_cur;
    assign bus.rk_round = r_round;
    assign bus.done     = r_done;
endmodule

`default_nettype wire
